// File: rtl/set_bit_sequencer.sv
// Serves the set bits of a pending request vector one per handshake, in priority order.
// The offer is held stable under backpressure; new requests merge in via i_Set or i_Load.
module set_bit_sequencer #(
    parameter int unsigned SIZE      = 8,
    parameter bit          MSB_FIRST = 1'b0,
    parameter int unsigned INDEX_W   = $clog2(SIZE)
) (
    input  logic               i_Clock,
    input  logic               i_Reset_n,
    input  logic               i_Load,
    input  logic [SIZE-1:0]    i_Vector,
    input  logic [SIZE-1:0]    i_Set,
    input  logic               i_Ready,
    output logic               o_Valid,
    output logic [SIZE-1:0]    o_OneHot,
    output logic [INDEX_W-1:0] o_Index,
    output logic [INDEX_W:0]   o_Count,
    output logic               o_Done
);

    localparam int unsigned COUNT_W = INDEX_W + 1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_OFFER = 1'b1
    } state_t;

    state_t             r_state;
    logic [SIZE-1:0]    r_pending;
    logic [SIZE-1:0]    r_onehot;
    logic [INDEX_W-1:0] r_index;
    logic [COUNT_W-1:0] r_count;
    logic               r_done;

    logic [SIZE-1:0]    w_acc;
    logic [SIZE-1:0]    w_p_next;
    logic [INDEX_W-1:0] w_sel_idx;
    logic [SIZE-1:0]    w_sel_oh;
    logic [COUNT_W-1:0] w_count;

    // Accepted bit this cycle and next pending vector; i_Set re-pends a bit accepted in the same cycle.
    always_comb begin
        w_acc    = '0;
        w_p_next = '0;
        if ((r_state == S_OFFER) && i_Ready) begin
            w_acc = r_onehot;
        end
        if (i_Load) begin
            w_p_next = i_Vector | i_Set;
        end else begin
            w_p_next = (r_pending & ~w_acc) | i_Set;
        end
    end

    // Priority pick of the next offer; the last matching iteration wins.
    always_comb begin
        w_sel_idx = '0;
        w_sel_oh  = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < int'(SIZE); i++) begin
                if (w_p_next[i]) begin
                    w_sel_idx = INDEX_W'(i);
                end
            end
        end else begin
            for (int i = int'(SIZE) - 1; i >= 0; i--) begin
                if (w_p_next[i]) begin
                    w_sel_idx = INDEX_W'(i);
                end
            end
        end
        if (|w_p_next) begin
            w_sel_oh = SIZE'(1) << w_sel_idx;
        end
    end

    always_comb begin
        w_count = '0;
        for (int i = 0; i < int'(SIZE); i++) begin
            w_count = w_count + COUNT_W'(w_p_next[i]);
        end
    end

    // Offer FSM; an offer only moves on acceptance or reload so the consumer sees a stable request.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_state   <= S_IDLE;
            r_pending <= '0;
            r_onehot  <= '0;
            r_index   <= '0;
            r_count   <= '0;
            r_done    <= 1'b0;
        end else begin
            r_pending <= w_p_next;
            r_count   <= w_count;
            r_done    <= (|w_acc) && !(|w_p_next);
            case (r_state)
                S_IDLE: begin
                    if (|w_p_next) begin
                        r_state  <= S_OFFER;
                        r_onehot <= w_sel_oh;
                        r_index  <= w_sel_idx;
                    end
                end
                S_OFFER: begin
                    if ((|w_acc) || i_Load) begin
                        r_state  <= (|w_p_next) ? S_OFFER : S_IDLE;
                        r_onehot <= w_sel_oh;
                        r_index  <= w_sel_idx;
                    end
                end
            endcase
        end
    end

    assign o_Valid  = (r_state == S_OFFER);
    assign o_OneHot = r_onehot;
    assign o_Index  = r_index;
    assign o_Count  = r_count;
    assign o_Done   = r_done;

endmodule

// File: tb/tb_set_bit_sequencer.sv
// Directed bench for set_bit_sequencer: an LSB-first and an MSB-first instance share stimulus,
// expected outputs are queued per step and compared just after each clock edge.
module tb_set_bit_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load;
    logic       ready;
    logic [7:0] vec;
    logic [7:0] set;

    logic       v0, v1, dn0, dn1;
    logic [7:0] oh0, oh1;
    logic [2:0] ix0, ix1;
    logic [3:0] ct0, ct1;

    typedef struct packed {
        logic       dut;
        logic       valid;
        logic [7:0] oh;
        logic [2:0] idx;
        logic [3:0] cnt;
        logic       done;
    } exp_t;

    exp_t  q[$];
    string tag;
    int    n_checks = 0;
    int    n_pass   = 0;

    always #5 clk = ~clk;

    set_bit_sequencer #(.SIZE(8), .MSB_FIRST(1'b0)) u_lsb (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_Load(load), .i_Vector(vec), .i_Set(set),
        .i_Ready(ready), .o_Valid(v0), .o_OneHot(oh0), .o_Index(ix0), .o_Count(ct0), .o_Done(dn0)
    );

    set_bit_sequencer #(.SIZE(8), .MSB_FIRST(1'b1)) u_msb (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_Load(load), .i_Vector(vec), .i_Set(set),
        .i_Ready(ready), .o_Valid(v1), .o_OneHot(oh1), .o_Index(ix1), .o_Count(ct1), .o_Done(dn1)
    );

    task automatic drive(input logic l, input logic [7:0] v, input logic [7:0] s, input logic r);
        load  = l;
        vec   = v;
        set   = s;
        ready = r;
    endtask

    task automatic expect_out(input int d, input logic v, input int idx, input int cnt, input logic dn);
        exp_t e;
        e.dut   = (d != 0);
        e.valid = v;
        e.idx   = v ? 3'(idx) : 3'd0;
        e.oh    = v ? (8'd1 << idx) : 8'd0;
        e.cnt   = 4'(cnt);
        e.done  = dn;
        q.push_back(e);
    endtask

    task automatic both(input logic v, input int i_lsb, input int i_msb, input int cnt, input logic dn);
        expect_out(0, v, i_lsb, cnt, dn);
        expect_out(1, v, i_msb, cnt, dn);
    endtask

    task automatic check_all();
        exp_t        e;
        logic [16:0] obs;
        logic [16:0] want;
        while (q.size() > 0) begin
            e    = q.pop_front();
            obs  = e.dut ? {v1, oh1, ix1, ct1, dn1} : {v0, oh0, ix0, ct0, dn0};
            want = {e.valid, e.oh, e.idx, e.cnt, e.done};
            n_checks++;
            assert (obs === want) n_pass++;
            else begin
                $display("FAIL %s dut%0d: observed v/oh/idx/cnt/done=%h required %h", tag, e.dut, obs, want);
                $error("check %s dut%0d mismatch", tag, e.dut);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        tag = "reset";
        repeat (2) @(posedge clk);
        #1;
        both(0, 0, 0, 0, 0);
        check_all();
        rst_n = 1'b1;
        tag = "idle";
        both(0, 0, 0, 0, 0);
        tick();

        tag = "drain";
        drive(1'b1, 8'hA6, 8'h00, 1'b1);
        both(1, 1, 7, 4, 0);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b1);
        both(1, 2, 5, 3, 0);
        tick();
        both(1, 5, 2, 2, 0);
        tick();
        both(1, 7, 1, 1, 0);
        tick();
        both(0, 0, 0, 0, 1);
        tick();
        both(0, 0, 0, 0, 0);
        tick();

        tag = "load_zero";
        drive(1'b1, 8'h00, 8'h00, 1'b1);
        both(0, 0, 0, 0, 0);
        tick();

        tag = "set_only";
        drive(1'b0, 8'h00, 8'h42, 1'b0);
        both(1, 1, 6, 2, 0);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b1);
        both(1, 6, 1, 1, 0);
        tick();
        both(0, 0, 0, 0, 1);
        tick();

        tag = "backpressure";
        drive(1'b1, 8'h10, 8'h00, 1'b0);
        both(1, 4, 4, 1, 0);
        tick();
        drive(1'b0, 8'h00, 8'h01, 1'b0);
        both(1, 4, 4, 2, 0);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        repeat (3) begin
            both(1, 4, 4, 2, 0);
            tick();
        end
        drive(1'b0, 8'h00, 8'h00, 1'b1);
        both(1, 0, 0, 1, 0);
        tick();
        both(0, 0, 0, 0, 1);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        both(0, 0, 0, 0, 0);
        tick();

        tag = "collision";
        drive(1'b1, 8'h08, 8'h00, 1'b0);
        both(1, 3, 3, 1, 0);
        tick();
        drive(1'b0, 8'h00, 8'h08, 1'b1);
        both(1, 3, 3, 1, 0);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b1);
        both(0, 0, 0, 0, 1);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        both(0, 0, 0, 0, 0);
        tick();

        tag = "load_mid_drain";
        drive(1'b1, 8'hF0, 8'h00, 1'b1);
        both(1, 4, 7, 4, 0);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b1);
        both(1, 5, 6, 3, 0);
        tick();
        drive(1'b1, 8'h21, 8'h00, 1'b1);
        both(1, 0, 5, 2, 0);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b1);
        both(1, 5, 0, 1, 0);
        tick();
        both(0, 0, 0, 0, 1);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        both(0, 0, 0, 0, 0);
        tick();

        tag = "reset_mid_drain";
        drive(1'b1, 8'hA5, 8'h00, 1'b1);
        both(1, 0, 7, 4, 0);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b1);
        both(1, 2, 5, 3, 0);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        both(0, 0, 0, 0, 0);
        check_all();
        both(0, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        tag = "after_reset";
        both(0, 0, 0, 0, 0);
        tick();
        both(0, 0, 0, 0, 0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/set_bit_sequencer.md
# set_bit_sequencer

Registered, handshaked sequencer that takes a pending request vector and serves its set bits one at a time in priority order (lowest index first by default, highest index first by parameter), clearing each bit as the consumer accepts it. It is the sequential, parametrised successor to the combinational lowest-set-bit isolator. It sits between request sources (interrupt flags, DMA/channel requests) and a single consumer that handles one request per handshake. New requests can be merged in while draining.

## Interface
- SIZE, 8, request vector width (≥2)
- MSB_FIRST, 0, 0 = lowest set index served first; 1 = highest set index served first
- INDEX_W, $clog2(SIZE), width of o_Index (derived; not overridden)
- i_Clock  in  1  sole clock, rising edge
- i_Reset_n  in  1  asynchronous, active-low reset
- i_Load  in  1  replace pending vector with i_Vector | i_Set
- i_Vector  in  SIZE  vector captured on i_Load
- i_Set  in  SIZE  bits OR-ed into pending every cycle
- i_Ready  in  1  consumer accepts current offer
- o_Valid  out  1  offer present
- o_OneHot  out  SIZE  one-hot offered bit (all zero when !o_Valid)
- o_Index  out  INDEX_W  binary index of offered bit (0 when !o_Valid)
- o_Count  out  INDEX_W+1  popcount of pending register
- o_Done  out  1  one-cycle pulse: last pending bit accepted, nothing remains

## Operation
- State: pending register P[SIZE], offer register (o_Valid, o_OneHot, o_Index), o_Done flop. Two states: IDLE (o_Valid=0) and OFFER (o_Valid=1).
- acc = (o_Valid & i_Ready) ? o_OneHot : 0.
- P_next = i_Load ? (i_Vector | i_Set) : ((P & ~acc) | i_Set). i_Set wins over acceptance on the same bit (bit re-pends).
- Offer update when (!o_Valid | acc != 0 | i_Load): o_Valid <= (P_next != 0); o_OneHot <= priority-isolated bit of P_next (lowest if MSB_FIRST=0, highest otherwise); o_Index <= its position. Otherwise the offer holds unchanged.
- Stability rule: while o_Valid & !i_Ready & !i_Load, o_OneHot/o_Index must not change, even if i_Set adds a higher-priority bit; that bit is served after the current handshake.
- i_Load mid-drain: handshake in the same cycle counts as accepted by the consumer, but P is replaced; if i_Vector contains the accepted bit it is offered again.
- Invariant: o_Valid implies o_OneHot ⊆ P and exactly one bit set.
- o_Count <= popcount(P_next) each cycle (reflects P register).
- o_Done <= (acc != 0) & (P_next == 0). Not asserted for i_Load of an all-zero vector.
- Reset (any time, async): P=0, o_Valid=0, o_OneHot=0, o_Index=0, o_Count=0, o_Done=0; in-flight offer is dropped without completion.

## Timing
- All outputs registered; no combinational path from inputs to outputs.
- Load/Set to first o_Valid: 1 cycle (set at edge t, visible after edge t).
- Throughput: one accepted bit per cycle with i_Ready held high; N set bits drain in N cycles after first offer.
- o_Done rises in the cycle after the final accepting edge, lasts exactly one cycle (unless a new load/drain immediately completes again).
- SIZE not a power of two: o_Index never exceeds SIZE-1.

## Test plan
- Reset: assert i_Reset_n low mid-drain of 8'hA5 -> all outputs 0 immediately, no o_Done; release -> stays IDLE.
- Drain LSB-first: i_Load with 8'b1010_0110, i_Ready=1 -> o_Index 1,2,5,7 on consecutive cycles, o_Count 4,3,2,1, o_Done pulse one cycle after index 7 accepted, o_Count 0.
- MSB_FIRST=1, same vector -> o_Index 7,5,2,1; o_OneHot 8'h80,8'h20,8'h04,8'h02.
- Backpressure + hold: load 8'h10, i_Ready=0, then i_Set=8'h01 -> offer stays index 4 for all stall cycles, o_Count 2; i_Ready=1 -> index 0 next, then o_Done.
- Set-vs-accept collision: offer index 3 accepted while i_Set=8'h08 -> bit 3 offered again next cycle, no o_Done.
- Load mid-drain: draining 8'hF0 at index 5, i_Load with 8'h21 and i_Ready=1 -> next offers index 0 then 5, o_Count 2 then 1, o_Done after index 5.
